// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I width codes,
// exception cause codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data, legality checks and
// load-lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic        illegal_o,
  output logic [31:0] load_data_o
);

  logic [31:0] lane;

  always_comb begin
    byte_en_o    = 4'b0000;
    wdata_o      = store_data_i;
    illegal_o    = 1'b0;
    misaligned_o = 1'b0;
    load_data_o  = 32'h0;
    lane         = rdata_i >> {addr_lo_i, 3'b000};

    if (is_store_i) begin
      illegal_o = (funct3_i > F3_W);
    end else begin
      illegal_o = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    end

    misaligned_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));

    // Loads never assert byte enables.
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          byte_en_o = 4'b0001 << addr_lo_i;
          wdata_o   = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          byte_en_o = 4'b0011 << {addr_lo_i[1], 1'b0};
          wdata_o   = {2{store_data_i[15:0]}};
        end
        2'b10: begin
          byte_en_o = 4'b1111;
          wdata_o   = store_data_i;
        end
        default: begin
          byte_en_o = 4'b0000;
          wdata_o   = store_data_i;
        end
      endcase
    end

    case (funct3_i)
      F3_B:    load_data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_data_o = {{16{lane[15]}}, lane[15:0]};
      F3_W:    load_data_o = rdata_i;
      F3_BU:   load_data_o = {24'h0, lane[7:0]};
      F3_HU:   load_data_o = {16'h0, lane[15:0]};
      default: load_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one op from exec, drives the data-memory port,
// waits for completion with a timeout, and produces writeback or exception strobes.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_valid_in,
  input  logic        lsu_is_store_in,
  input  logic [2:0]  lsu_funct3_in,
  input  logic [31:0] lsu_addr_in,
  input  logic [31:0] lsu_store_data_in,
  input  logic [4:0]  lsu_rd_addr_in,
  output logic        lsu_busy_out,
  output logic        lsu_wb_valid_out,
  output logic [4:0]  lsu_wb_addr_out,
  output logic [31:0] lsu_wb_data_out,
  output logic        lsu_exc_valid_out,
  output logic [1:0]  lsu_exc_cause_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_write_byte_en_out,
  input  logic        mem_valid_in,
  input  logic [31:0] mem_rdata_in
);

  lsu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        store_q, store_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_cause_q, exc_cause_d;

  logic        al_is_store;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_misaligned;
  logic        al_illegal;
  logic [31:0] al_load_data;
  logic        accept;

  // Decode the incoming request in IDLE; afterwards the latched op drives extraction.
  assign al_is_store = (state_q == StIdle) ? lsu_is_store_in   : store_q;
  assign al_funct3   = (state_q == StIdle) ? lsu_funct3_in     : f3_q;
  assign al_addr_lo  = (state_q == StIdle) ? lsu_addr_in[1:0]  : addr_q[1:0];

  lsu_align u_align (
    .is_store_i   (al_is_store),
    .funct3_i     (al_funct3),
    .addr_lo_i    (al_addr_lo),
    .store_data_i (lsu_store_data_in),
    .rdata_i      (mem_rdata_in),
    .byte_en_o    (al_be),
    .wdata_o      (al_wdata),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal),
    .load_data_o  (al_load_data)
  );

  assign accept = (state_q == StIdle) && lsu_req_valid_in && !al_illegal && !al_misaligned;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    store_d     = store_q;
    wb_data_d   = wb_data_q;
    wb_addr_d   = wb_addr_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (lsu_req_valid_in) begin
          if (al_illegal) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EXC_ILLEGAL;
          end else if (al_misaligned) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EXC_MISALIGN;
          end else begin
            addr_d  = {lsu_addr_in[31:2], 2'b00};
            wdata_d = al_wdata;
            be_d    = al_be;
            f3_d    = lsu_funct3_in;
            rd_d    = lsu_rd_addr_in;
            store_d = lsu_is_store_in;
            addr_d[1:0] = lsu_addr_in[1:0];
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (mem_valid_in) begin
          wb_data_d = al_load_data;
          wb_addr_d = rd_q;
          cnt_d     = '0;
          state_d   = StResp;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          exc_valid_d = 1'b1;
          exc_cause_d = EXC_TIMEOUT;
          cnt_d       = '0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      f3_q        <= 3'h0;
      rd_q        <= 5'h0;
      store_q     <= 1'b0;
      wb_data_q   <= 32'h0;
      wb_addr_q   <= 5'h0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      store_q     <= store_d;
      wb_data_q   <= wb_data_d;
      wb_addr_q   <= wb_addr_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  assign lsu_busy_out          = accept || (state_q == StWait);
  assign lsu_wb_valid_out      = (state_q == StResp) && !store_q && (rd_q != 5'd0);
  assign lsu_wb_addr_out       = wb_addr_q;
  assign lsu_wb_data_out       = wb_data_q;
  assign lsu_exc_valid_out     = exc_valid_q;
  assign lsu_exc_cause_out     = exc_cause_q;
  assign mem_req_out           = (state_q == StWait);
  assign mem_addr_out          = {addr_q[31:2], 2'b00};
  assign mem_wdata_out         = wdata_q;
  assign mem_write_byte_en_out = be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: stores, loads, exceptions, timeout and
// asynchronous reset in the middle of an access.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lsu_req_valid_in = 1'b0;
  logic        lsu_is_store_in = 1'b0;
  logic [2:0]  lsu_funct3_in = 3'b0;
  logic [31:0] lsu_addr_in = 32'h0;
  logic [31:0] lsu_store_data_in = 32'h0;
  logic [4:0]  lsu_rd_addr_in = 5'h0;
  logic        lsu_busy_out;
  logic        lsu_wb_valid_out;
  logic [4:0]  lsu_wb_addr_out;
  logic [31:0] lsu_wb_data_out;
  logic        lsu_exc_valid_out;
  logic [1:0]  lsu_exc_cause_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_write_byte_en_out;
  logic        mem_valid_in = 1'b0;
  logic [31:0] mem_rdata_in = 32'h0;

  int tests = 0;
  int fails = 0;

  int          r_busy, r_wb, r_exc, r_req, r_exc_idx, r_wb_idx, r_unstable;
  logic [1:0]  r_cause;
  logic [31:0] r_wb_data, r_addr, r_wdata;
  logic [4:0]  r_wb_addr;
  logic [3:0]  r_be;

  lsu_ctrl #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .lsu_req_valid_in      (lsu_req_valid_in),
    .lsu_is_store_in       (lsu_is_store_in),
    .lsu_funct3_in         (lsu_funct3_in),
    .lsu_addr_in           (lsu_addr_in),
    .lsu_store_data_in     (lsu_store_data_in),
    .lsu_rd_addr_in        (lsu_rd_addr_in),
    .lsu_busy_out          (lsu_busy_out),
    .lsu_wb_valid_out      (lsu_wb_valid_out),
    .lsu_wb_addr_out       (lsu_wb_addr_out),
    .lsu_wb_data_out       (lsu_wb_data_out),
    .lsu_exc_valid_out     (lsu_exc_valid_out),
    .lsu_exc_cause_out     (lsu_exc_cause_out),
    .mem_req_out           (mem_req_out),
    .mem_addr_out          (mem_addr_out),
    .mem_wdata_out         (mem_wdata_out),
    .mem_write_byte_en_out (mem_write_byte_en_out),
    .mem_valid_in          (mem_valid_in),
    .mem_rdata_in          (mem_rdata_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, complete it after wait_n WAIT cycles (0 = never), and record what the
  // DUT did over a fixed window long enough to cover the timeout.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input int wait_n,
                        input logic [31:0] rdata);
    r_busy = 0; r_wb = 0; r_exc = 0; r_req = 0; r_exc_idx = -1; r_wb_idx = -1;
    r_unstable = 0; r_cause = 2'b00; r_wb_data = 32'h0; r_wb_addr = 5'h0;
    r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'h0;
    lsu_req_valid_in  = 1'b1;
    lsu_is_store_in   = st;
    lsu_funct3_in     = f3;
    lsu_addr_in       = addr;
    lsu_store_data_in = data;
    lsu_rd_addr_in    = rd;
    #1;
    r_busy += int'(lsu_busy_out);
    @(posedge clk); #1;
    lsu_req_valid_in  = 1'b0;
    lsu_store_data_in = 32'h0;
    for (int i = 0; i < 24; i++) begin
      mem_valid_in = (wait_n > 0) && (i == wait_n - 1);
      mem_rdata_in = mem_valid_in ? rdata : 32'h5A5A_5A5A;
      #1;
      if (mem_req_out) begin
        if (r_req == 0) begin
          r_addr  = mem_addr_out;
          r_wdata = mem_wdata_out;
          r_be    = mem_write_byte_en_out;
        end else if (mem_addr_out !== r_addr || mem_wdata_out !== r_wdata ||
                     mem_write_byte_en_out !== r_be) begin
          r_unstable++;
        end
        r_req++;
      end
      r_busy += int'(lsu_busy_out);
      if (lsu_wb_valid_out) begin
        r_wb++;
        r_wb_idx  = i;
        r_wb_data = lsu_wb_data_out;
        r_wb_addr = lsu_wb_addr_out;
      end
      if (lsu_exc_valid_out) begin
        r_exc++;
        r_exc_idx = i;
        r_cause   = lsu_exc_cause_out;
      end
      @(posedge clk); #1;
    end
    mem_valid_in = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_busy", 32'(lsu_busy_out), 32'h0);
    chk("rst_req", 32'(mem_req_out), 32'h0);
    chk("rst_wb", 32'(lsu_wb_valid_out), 32'h0);
    chk("rst_exc", 32'(lsu_exc_valid_out), 32'h0);
    chk("rst_addr", mem_addr_out, 32'h0);
    chk("rst_be", 32'(mem_write_byte_en_out), 32'h0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // SW, completes in the 3rd WAIT cycle
    access(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 5'd0, 3, 32'h0);
    chk("sw_addr", r_addr, 32'h104);
    chk("sw_be", 32'(r_be), 32'hF);
    chk("sw_wdata", r_wdata, 32'hDEAD_BEEF);
    chk("sw_busy", r_busy, 4);
    chk("sw_req", r_req, 3);
    chk("sw_stable", r_unstable, 0);
    chk("sw_wb", r_wb, 0);
    chk("sw_exc", r_exc, 0);

    access(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd0, 1, 32'h0);
    chk("sb_addr", r_addr, 32'h100);
    chk("sb_be", 32'(r_be), 32'h8);
    chk("sb_wdata", r_wdata, 32'hA5A5_A5A5);

    access(1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 5'd0, 2, 32'h0);
    chk("sh_be", 32'(r_be), 32'hC);
    chk("sh_wdata", r_wdata, 32'hBEEF_BEEF);

    // LB with one WAIT cycle: writeback two cycles after acceptance
    access(1'b0, 3'b000, 32'h102, 32'h0, 5'd5, 1, 32'h12F0_3456);
    chk("lb_data", r_wb_data, 32'hFFFF_FFF0);
    chk("lb_addr", 32'(r_wb_addr), 32'd5);
    chk("lb_strobes", r_wb, 1);
    chk("lb_lat", r_wb_idx, 1);
    chk("lb_be", 32'(r_be), 32'h0);
    chk("lb_busy", r_busy, 2);

    access(1'b0, 3'b100, 32'h102, 32'h0, 5'd5, 1, 32'h12F0_3456);
    chk("lbu_data", r_wb_data, 32'h0000_00F0);

    access(1'b0, 3'b001, 32'h102, 32'h0, 5'd7, 4, 32'h8000_3456);
    chk("lh_data", r_wb_data, 32'hFFFF_8000);
    chk("lh_lat", r_wb_idx, 4);

    access(1'b0, 3'b101, 32'h100, 32'h0, 5'd9, 2, 32'h12F0_8765);
    chk("lhu_data", r_wb_data, 32'h0000_8765);

    access(1'b0, 3'b010, 32'h104, 32'h0, 5'd31, 2, 32'hCAFE_F00D);
    chk("lw_data", r_wb_data, 32'hCAFE_F00D);
    chk("lw_addr", 32'(r_wb_addr), 32'd31);

    access(1'b0, 3'b010, 32'h104, 32'h0, 5'd0, 2, 32'hCAFE_F00D);
    chk("rd0_wb", r_wb, 0);

    access(1'b0, 3'b010, 32'h102, 32'h0, 5'd3, 0, 32'h0);
    chk("mis_exc", r_exc, 1);
    chk("mis_cause", 32'(r_cause), 32'h1);
    chk("mis_idx", r_exc_idx, 0);
    chk("mis_req", r_req, 0);
    chk("mis_busy", r_busy, 0);

    access(1'b0, 3'b011, 32'h100, 32'h0, 5'd3, 0, 32'h0);
    chk("ill_cause", 32'(r_cause), 32'h2);
    chk("ill_req", r_req, 0);

    access(1'b1, 3'b011, 32'h101, 32'h0, 5'd0, 0, 32'h0);
    chk("ill_prio", 32'(r_cause), 32'h2);

    // No completion: timeout after 16 WAIT cycles
    access(1'b0, 3'b010, 32'h200, 32'h0, 5'd4, 0, 32'h0);
    chk("to_req", r_req, 16);
    chk("to_exc", r_exc, 1);
    chk("to_cause", 32'(r_cause), 32'h3);
    chk("to_idx", r_exc_idx, 16);
    chk("to_wb", r_wb, 0);

    // Reset mid-WAIT
    lsu_req_valid_in = 1'b1;
    lsu_is_store_in  = 1'b0;
    lsu_funct3_in    = 3'b010;
    lsu_addr_in      = 32'h300;
    lsu_rd_addr_in   = 5'd6;
    @(posedge clk); #1;
    lsu_req_valid_in = 1'b0;
    @(posedge clk); #1;
    chk("mid_req", 32'(mem_req_out), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("ar_req", 32'(mem_req_out), 32'h0);
    chk("ar_busy", 32'(lsu_busy_out), 32'h0);
    chk("ar_addr", mem_addr_out, 32'h0);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    r_wb = 0;
    r_exc = 0;
    mem_valid_in = 1'b1;
    mem_rdata_in = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      r_wb  += int'(lsu_wb_valid_out);
      r_exc += int'(lsu_exc_valid_out);
      @(posedge clk); #1;
      mem_valid_in = 1'b0;
    end
    chk("ar_nowb", r_wb, 0);
    chk("ar_noexc", r_exc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sitting directly downstream of exec. Takes one decoded load/store per request and drives the CPU data-memory port (cpu_mem_* side): word-aligned address, replicated write data and byte enables. Waits for the memory valid handshake, then sign- or zero-extends load data into a one-cycle writeback to regs. Holds the pipeline through flush_ctrl while an access is outstanding, and reports misaligned, illegal-width and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles in WAIT without mem_valid_in before the access is aborted (1..255)
CNT_W, 8, width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
lsu_req_valid_in  in  1  exec presents a load/store this cycle
lsu_is_store_in  in  1  1 = store, 0 = load
lsu_funct3_in  in  3  RV32I width/sign code (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010)
lsu_addr_in  in  32  effective byte address
lsu_store_data_in  in  32  rs2 value
lsu_rd_addr_in  in  5  load destination register
lsu_busy_out  out  1  pipeline hold request to flush_ctrl
lsu_wb_valid_out  out  1  one-cycle writeback strobe
lsu_wb_addr_out  out  5  writeback register
lsu_wb_data_out  out  32  extended load data
lsu_exc_valid_out  out  1  one-cycle exception strobe
lsu_exc_cause_out  out  2  01 misaligned, 10 illegal funct3, 11 timeout
mem_req_out  out  1  bus request, held high until accepted
mem_addr_out  out  32  {addr[31:2],2'b00}
mem_wdata_out  out  32  lane-replicated store data
mem_write_byte_en_out  out  4  byte enables; 4'b0000 for loads
mem_valid_in  in  1  memory completes the current request
mem_rdata_in  in  32  read word, valid with mem_valid_in

Behaviour:
- Reset: state IDLE; counter 0; every output 0. Reset is asynchronous: asserting it in WAIT drops mem_req_out immediately, and no writeback or exception follows.
- FSM states: IDLE, WAIT, RESP.
- IDLE, request valid, legal and aligned: latch address, data, funct3, rd and kind. Next state is WAIT. lsu_busy_out=1 combinationally in that same cycle so exec holds.
- IDLE, request illegal (load funct3 in {011,110,111}, or store funct3>010): no bus access, busy stays 0, lsu_exc_valid_out pulses next cycle with cause 10. Illegal takes priority over misaligned.
- IDLE, request misaligned (half-word with addr[0]=1; word with addr[1:0]!=0): no bus access, exception pulse next cycle with cause 01.
- WAIT outputs: mem_req_out=1 and busy=1; address, wdata and byte enables held stable.
- Byte enables: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<{addr[1],1'b0}; SW = 4'b1111.
- Write data: SB = {4{d[7:0]}}; SH = {2{d[15:0]}}; SW = d.
- WAIT, mem_valid_in=1: capture the lane selected by addr[1:0] and extend it per funct3 (LB/LH sign, LBU/LHU zero, LW whole word). Next state is RESP. Latency from acceptance to writeback is (wait cycles + 2).
- WAIT without valid: counter increments. When counter = TIMEOUT_CYCLES-1 with no valid, go to IDLE with an exception pulse, cause 11, and no writeback.
- RESP: busy=0. For a load with rd!=0, lsu_wb_valid_out=1 for this one cycle; rd=0 suppresses the strobe. A store does not strobe. lsu_req_valid_in is ignored in RESP because it is the held copy of the completed op. Next state is IDLE.
- mem_valid_in arriving in IDLE or RESP is ignored.
- wb_addr and wb_data hold their values after the strobe; they are only meaningful while the strobe is high.

Decomposition:
- Shared package lsu_pkg: state encoding; funct3 constants; exception cause codes (EXC_MISALIGN, EXC_ILLEGAL, EXC_TIMEOUT).
- One natural combinational sub-module, lsu_align: funct3 + addr[1:0] + data in, giving byte enables, replicated wdata, the misaligned/illegal flags, and load extraction with extension.
- The FSM and timeout counter stay in lsu_ctrl.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, mem_valid after 3 cycles -> mem_addr 0x104, byte_en 1111, wdata 0xDEADBEEF, busy high 4 cycles, no wb strobe.
- SB addr 0x103, data 0x000000A5 -> byte_en 1000, wdata 0xA5A5A5A5.
- LB addr 0x102, rdata 0x12F03456, rd=5 -> wb_data 0xFFFFFFF0, wb_addr 5, one-cycle strobe.
- Same access as LBU -> wb_data 0x000000F0.
- LW addr 0x102 -> exc cause 01, mem_req never rises, busy stays 0. Load funct3=011 -> exc cause 10.
- Load with no mem_valid -> exc cause 11 after exactly 16 WAIT cycles, mem_req drops, no strobe.
- Reset asserted mid-WAIT -> all outputs 0 at once; a later mem_valid produces no strobe.
